sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller that sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM. It replaces the single-cycle data memory behind the MEM stage: each load or store is split into a low-half and a high-half SRAM access, with programmable wait cycles. While an access is in flight it drives `ready` low, and the top level uses `~ready` to freeze every pipeline register.

## Interface
Parameters:
- `HALF_CYCLES`, default 2: cycles spent on each 16-bit half access. Must be ≥ 2.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request, held stable by the frozen pipeline.
- `rd_en` in 1: load request, held stable by the frozen pipeline.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store value.
- `read_data` out 32: load result, registered.
- `ready` out 1: 0 while an access is in flight; pipeline freeze = `~ready`.
- `sram_addr` out 18: SRAM half-word address.
- `sram_we_n` out 1: SRAM write strobe, active-low.
- `sram_dq_o` out 16: write data to the SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_o` (the pad is at top level).
- `sram_dq_i` in 16: read data from the SRAM.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter `cnt` of width clog2(HALF_CYCLES) counts cycles within LOW and HIGH.
- IDLE:
  - `rd_en|wr_en` → latch op (wr priority if both), go to LOW, `cnt`=0.
  - Otherwise stay in IDLE.
- LOW and HIGH:
  - `cnt` increments each cycle.
  - When `cnt`==HALF_CYCLES-1: LOW→HIGH or HIGH→DONE, and `cnt`←0.
- DONE: unconditionally → IDLE after 1 cycle.
- Address mapping: `word = (address - BASE_ADDR)[18:2]` (17 bits, wraps modulo; no range check). `sram_addr = {word, 1'b0}` in LOW and `{word, 1'b1}` in HIGH. Outside LOW/HIGH, `sram_addr` holds its last value.
- Write op:
  - `sram_dq_oe`=1 throughout LOW and HIGH.
  - `sram_dq_o` = `write_data[15:0]` in LOW, `write_data[31:16]` in HIGH.
  - `sram_we_n`=0 except in the last cycle of each phase, which gives address/data hold.
- Read op:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `read_data[15:0]` ← `sram_dq_i` on the last cycle of LOW.
  - `read_data[31:16]` ← `sram_dq_i` on the last cycle of HIGH.
  - `read_data` holds until the next read overwrites it. Writes never touch it.
- `ready` (combinational): 1 in DONE; 1 in IDLE when `rd_en|wr_en`=0; 0 otherwise.
- Once started, an access always completes even if requests drop. Requests are ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0.
  - `read_data`=0, `sram_addr`=0, `sram_we_n`=1, `sram_dq_o`=0, `sram_dq_oe`=0.
  - `ready` = ~(`rd_en|wr_en`).
- Request first seen in cycle 0 (IDLE):
  - `ready`=0 in cycles 0..2·HALF_CYCLES.
  - `ready`=1 in cycle 2·HALF_CYCLES+1 (DONE). That is 5 stall cycles at the default.
- Pipeline registers advance at the edge ending DONE. The next request is therefore seen in IDLE with no bubble and no double issue.
- Back-to-back accesses: DONE→IDLE→LOW, so the minimum period is 2·HALF_CYCLES+2 cycles.
- Reset mid-access: immediate return to IDLE, `sram_we_n`=1, `sram_dq_oe`=0. A partially updated `read_data` is cleared to 0.
- Simultaneous `rd_en` and `wr_en`: performed as a write.

## Structure
- Shared package `arm_pkg`: state enum (IDLE/LOW/HIGH/DONE) and constant `DATA_MEM_BASE`=1024, reused by the MEM stage and the bench.
- One natural sub-module, `sram_phase_counter`: clear/enable counter with a terminal-count output at HALF_CYCLES-1. The FSM and datapath stay in `sram_controller`.
- The top level instantiates the controller in place of the data memory. `freeze` becomes `hazard | ~ready`, and the tri-state pad lives in the top level.

## Test plan
- Store `address`=1024, `write_data`=0xDEADBEEF, HALF_CYCLES=2:
  - `sram_addr`=0 with `sram_dq_o`=0xBEEF, then `sram_addr`=1 with 0xDEAD.
  - `sram_we_n` pattern per half is 0,1.
  - `ready`=0 for 5 cycles, then 1 for one cycle.
- Load `address`=1028 with the SRAM model holding half-words 0x1234 at 2 and 0x5678 at 3: `read_data`=0x56781234 in DONE and held afterwards.
- Back-to-back store then load of the same address (1032, value 0x0BADF00D): the load returns 0x0BADF00D, the second access starts in IDLE the cycle after DONE, and the period is 6 cycles.
- Assert `rst` during HIGH of a store: next cycle state=IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0. A following load completes normally.
- `rd_en`=`wr_en`=1 with `address`=1024: a write is performed (`sram_dq_oe`=1) and `read_data` is unchanged. `rd_en` dropped in LOW: the access still completes and `ready` pulses in DONE.
- Idle with no request for 10 cycles: `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0 throughout.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the MEM stage: SRAM sequencing states, data-memory base
// address and the byte-address to SRAM-word mapping.
package arm_pkg;

    localparam int DATA_MEM_BASE = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    // Word index of a byte address relative to the base; wraps modulo 2^17.
    function automatic logic [16:0] sram_word(input logic [31:0] address, input logic [31:0] base);
        return 17'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Bundle between the MEM stage / SRAM pad (master) and the controller (slave).
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_i,
        input  read_data, ready, sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_i,
        output read_data, ready, sram_addr, sram_we_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/sram_phase_counter.sv
// Cycle counter for one SRAM half access: clear has priority over enable, and
// o_tc flags the last cycle of the phase.
module sram_phase_counter #(
    parameter int HALF_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(HALF_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into a low and a high 16-bit async-SRAM access,
// holding ready low so the pipeline freezes until the access completes.
module sram_controller
    import arm_pkg::*;
#(
    parameter int HALF_CYCLES = 2,
    parameter int BASE_ADDR   = DATA_MEM_BASE
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus
);
    sram_state_t r_state;
    sram_state_t w_state_next;

    logic        r_is_write;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;
    logic [17:0] r_addr_hold;

    logic        w_req;
    logic        w_active;
    logic        w_tc;
    logic        w_write_phase;
    logic [17:0] w_sram_addr;

    assign w_req         = bus.rd_en | bus.wr_en;
    assign w_active      = (r_state == LOW) || (r_state == HIGH);
    assign w_write_phase = w_active && r_is_write;

    sram_phase_counter #(.HALF_CYCLES(HALF_CYCLES)) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (~w_active | w_tc),
        .i_en    (w_active),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_next = LOW;
            LOW:     if (w_tc)  w_state_next = HIGH;
            HIGH:    if (w_tc)  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state <= w_state_next;
            // Capture the request once so a dropped enable cannot disturb the access.
            if (r_state == IDLE && w_req) begin
                r_is_write <= bus.wr_en;
                r_word     <= sram_word(bus.address, 32'(BASE_ADDR));
                r_wdata    <= bus.write_data;
            end
            if (w_active) begin
                r_addr_hold <= w_sram_addr;
            end
            if (w_active && w_tc && !r_is_write) begin
                if (r_state == LOW) begin
                    r_read_data[15:0] <= bus.sram_dq_i;
                end else begin
                    r_read_data[31:16] <= bus.sram_dq_i;
                end
            end
        end
    end

    assign w_sram_addr = w_active ? {r_word, (r_state == HIGH)} : r_addr_hold;

    // Strobe released on the final cycle of each phase for address/data hold.
    assign bus.sram_we_n  = ~(w_write_phase && !w_tc);
    assign bus.sram_dq_oe = w_write_phase;
    assign bus.sram_dq_o  = w_write_phase ? ((r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0]) : 16'h0000;
    assign bus.sram_addr  = w_sram_addr;
    assign bus.read_data  = r_read_data;
    assign bus.ready      = (r_state == DONE) || ((r_state == IDLE) && !w_req);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM and a
// read-data scoreboard.
module tb_sram_controller;
    import arm_pkg::*;

    localparam int HC = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] rd_q[$];
    logic [31:0] last_rd;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_controller_if bus();

    sram_controller #(.HALF_CYCLES(HC), .BASE_ADDR(DATA_MEM_BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural SRAM: reset restores the preload, a low strobe writes.
    assign bus.sram_dq_i = mem[bus.sram_addr[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[2] <= 16'h1234;
            mem[3] <= 16'h5678;
        end else if (!bus.sram_we_n) begin
            mem[bus.sram_addr[7:0]] <= bus.sram_dq_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Issues one access in the cycle after the call and returns at the DONE negedge.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit drop_rd, output int start_cyc);
        logic [16:0] word;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        int          phase;
        bit          last;
        logic [31:0] e;
        word = 17'((addr - 32'(DATA_MEM_BASE)) >> 2);
        @(posedge clk);
        #1;
        bus.wr_en = we;
        bus.rd_en = re;
        bus.address = addr;
        bus.write_data = wd;
        if (re && !we) rd_q.push_back(exp_rd);
        @(negedge clk);
        start_cyc = cyc;
        chk("ready_cycle0", 32'(bus.ready), 32'd0);
        for (int k = 1; k <= 2 * HC; k++) begin
            @(negedge clk);
            phase = (k - 1) / HC;
            last = (((k - 1) % HC) == HC - 1);
            exp_addr = {word, phase[0]};
            exp_dq = (phase == 0) ? wd[15:0] : wd[31:16];
            chk("ready_busy", 32'(bus.ready), 32'd0);
            chk("sram_addr", 32'(bus.sram_addr), 32'(exp_addr));
            chk("sram_we_n", 32'(bus.sram_we_n), we ? 32'(last) : 32'd1);
            chk("sram_dq_oe", 32'(bus.sram_dq_oe), 32'(we));
            if (we) chk("sram_dq_o", 32'(bus.sram_dq_o), 32'(exp_dq));
            if (drop_rd && k == 1) bus.rd_en = 1'b0;
        end
        @(negedge clk);
        chk("ready_done", 32'(bus.ready), 32'd1);
        chk("addr_hold_done", 32'(bus.sram_addr), 32'({word, 1'b1}));
        if (we) begin
            chk("wr_keeps_rdata", bus.read_data, last_rd);
        end else if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("read_data", bus.read_data, e);
            last_rd = e;
        end
        $display("txn %s addr=%0d wdata=%h read_data=%h start=%0d",
                 we ? "WR" : "RD", addr, wd, bus.read_data, start_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, s1;
        rst = 1'b1;
        last_rd = 32'h0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.address = 32'h0;
        bus.write_data = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
        chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst_dq_o", 32'(bus.sram_dq_o), 32'h0);
        chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("rst_ready_noreq", 32'(bus.ready), 32'd1);
        bus.rd_en = 1'b1;
        #1;
        chk("rst_ready_req", 32'(bus.ready), 32'd0);
        bus.rd_en = 1'b0;
        #1;
        chk("rst_ready_back", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Store then load of the preloaded words.
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0, s0);
        go_idle();
        access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h56781234, 1'b0, s0);
        go_idle();
        @(negedge clk);
        chk("rdata_held", bus.read_data, 32'h56781234);

        // Back-to-back store/load, no bubble between them.
        access(1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 32'h0, 1'b0, s0);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 32'h0BADF00D, 1'b0, s1);
        chk("b2b_period", 32'(s1 - s0), 32'(2 * HC + 2));
        go_idle();

        // Reset in the high phase of a store.
        @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.address = 32'd1040;
        bus.write_data = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        chk("pre_rst_dq_oe", 32'(bus.sram_dq_oe), 32'd1);
        rst = 1'b1;
        go_idle();
        #1;
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("mid_rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("mid_rst_rdata", bus.read_data, 32'h0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h56781234, 1'b0, s0);
        go_idle();

        // Both enables: a write wins; then a load whose rd_en drops in LOW.
        access(1'b1, 1'b1, 32'd1024, 32'h13572468, 32'h0, 1'b0, s0);
        go_idle();
        access(1'b0, 1'b1, 32'd1024, 32'h0, 32'h13572468, 1'b1, s0);
        go_idle();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.ready), 32'd1);
            chk("idle_we_n", 32'(bus.sram_we_n), 32'd1);
            chk("idle_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
